mc_control_fsm: RTL



---
 rtl/mc_control_fsm_if.sv | 46 ++++
 rtl/mc_control_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Opcode/memory handshake and datapath control bundle between the
//               multicycle control FSM and the datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             mem_req;
    logic             branch;
    logic             pc_update;
    logic             reg_write;
    logic             mem_write;
    logic             ir_write;
    logic             adr_src;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    // Control FSM side
    modport master (
        input  op, mem_ready,
        output mem_req, branch, pc_update, reg_write, mem_write, ir_write,
               adr_src, result_src, alu_src_a, alu_src_b, alu_op,
               trap, trap_cause, retired
    );

    // Datapath / memory side
    modport slave (
        output op, mem_ready,
        input  mem_req, branch, pc_update, reg_write, mem_write, ir_write,
               adr_src, result_src, alu_src_a, alu_src_b, alu_op,
               trap, trap_cause, retired
    );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module      : mc_control_fsm
// Description : Main control FSM of the multicycle RV32I core with bounded
//               memory wait, sticky trap state and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mc_control_fsm_if.master bus
);

    localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_JAL      = 4'd9;
    localparam logic [3:0] c_BEQ      = 4'd10;
    localparam logic [3:0] c_AUIPC    = 4'd11;
    localparam logic [3:0] c_LUI      = 4'd12;
    localparam logic [3:0] c_TRAP     = 4'd13;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [1:0]        w_cause_next;
    logic [1:0]        r_cause;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;

    logic w_mem_req;
    logic w_stall;
    logic w_timeout;
    logic w_enter_mem;
    logic w_retire;

    assign w_mem_req = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                       (r_state == c_MEMWRITE);
    assign w_stall   = w_mem_req && !bus.mem_ready;
    assign w_timeout = (WAIT_MAX > 0) && w_stall && (r_wait == c_WAIT_LIMIT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_cause_next = 2'b00;
        case (r_state)
            c_FETCH: begin
                if (w_timeout) begin
                    w_next       = c_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    w_next = c_DECODE;
                end
            end
            c_DECODE: begin
                case (bus.op)
                    c_OP_R:                         w_next = c_EXECR;
                    c_OP_I:                         w_next = c_EXECI;
                    c_OP_LOAD, c_OP_STORE, c_OP_JALR: w_next = c_MEMADR;
                    c_OP_BR:                        w_next = c_BEQ;
                    c_OP_JAL:                       w_next = c_JAL;
                    c_OP_AUIPC:                     w_next = c_AUIPC;
                    c_OP_LUI:                       w_next = c_LUI;
                    default: begin
                        w_next       = c_TRAP;
                        w_cause_next = c_CAUSE_ILLEGAL;
                    end
                endcase
            end
            c_MEMADR: begin
                // JALR shares the address computation, then finishes like JAL
                if (!bus.op[5]) begin
                    w_next = c_MEMREAD;
                end else if (bus.op[6]) begin
                    w_next = c_JAL;
                end else begin
                    w_next = c_MEMWRITE;
                end
            end
            c_MEMREAD: begin
                if (w_timeout) begin
                    w_next       = c_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    w_next = c_MEMWB;
                end
            end
            c_MEMWRITE: begin
                if (w_timeout) begin
                    w_next       = c_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end else if (bus.mem_ready) begin
                    w_next = c_FETCH;
                end
            end
            c_MEMWB:  w_next = c_FETCH;
            c_EXECR:  w_next = c_ALUWB;
            c_EXECI:  w_next = c_ALUWB;
            c_ALUWB:  w_next = c_FETCH;
            c_JAL:    w_next = c_ALUWB;
            c_AUIPC:  w_next = c_ALUWB;
            c_BEQ:    w_next = c_FETCH;
            c_LUI:    w_next = c_FETCH;
            c_TRAP:   w_next = c_TRAP;
            default:  w_next = c_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic (FETCH ir_write/pc_update follow mem_ready)
    // ------------------------------------------------------------------------
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.branch     = 1'b0;
        bus.pc_update  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.trap       = 1'b0;
        case (r_state)
            c_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_update  = bus.mem_ready;
            end
            c_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            c_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            c_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
            end
            c_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b01;
            end
            c_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            c_EXECR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            c_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            c_ALUWB: begin
                bus.reg_write = 1'b1;
            end
            c_JAL: begin
                bus.pc_update = 1'b1;
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
            end
            c_AUIPC: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            c_BEQ: begin
                bus.branch    = 1'b1;
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
            end
            c_LUI: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b11;
            end
            c_TRAP: begin
                bus.trap = 1'b1;
            end
            default: begin
                bus.trap = 1'b0;
            end
        endcase
    end

    assign bus.trap_cause = r_cause;
    assign bus.retired    = r_retired;

    // ------------------------------------------------------------------------
    // Trap cause, memory wait counter and retired-instruction counter
    // ------------------------------------------------------------------------
    assign w_enter_mem = (w_next != r_state) &&
                         ((w_next == c_FETCH) || (w_next == c_MEMREAD) ||
                          (w_next == c_MEMWRITE));

    assign w_retire = (r_state == c_MEMWB) || (r_state == c_ALUWB) ||
                      (r_state == c_BEQ)   || (r_state == c_LUI)   ||
                      ((r_state == c_MEMWRITE) && bus.mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause <= 2'b00;
        end else if ((w_next == c_TRAP) && (r_state != c_TRAP)) begin
            r_cause <= w_cause_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (bus.mem_ready || w_enter_mem || (w_next == c_TRAP)) begin
            r_wait <= '0;
        end else if (w_stall) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

endmodule

`default_nettype wire
